// File: rtl/solar_display_sequencer_if.sv
// Channel bus for the solar display sequencer: packed channel inputs, selection controls
// and the valid/ready sample output.
interface solar_display_sequencer_if #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned NCH   = 5
);
  localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] ch_data;
  logic                 mode;
  logic [SW-1:0]        sel;
  logic [NCH-1:0]       ch_en;
  logic [WIDTH-1:0]     out_data;
  logic [SW-1:0]        out_ch;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output ch_data, mode, sel, ch_en, out_ready,
    input  out_data, out_ch, out_valid
  );

  modport slave (
    input  ch_data, mode, sel, ch_en, out_ready,
    output out_data, out_ch, out_valid
  );
endinterface

// File: rtl/solar_display_sequencer.sv
// Samples one display channel every DWELL cycles (manual select or auto-scan over enabled
// channels) into a registered valid/ready output slot that never drops a pending sample.
module solar_display_sequencer #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned NCH   = 5,
  parameter int unsigned DWELL = 1024
) (
  input logic                    clk,
  input logic                    rst,
  solar_display_sequencer_if.slave bus
);
  localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CntLast = CW'(DWELL - 1);
  localparam logic [SW-1:0] LastCh  = SW'(NCH - 1);

  typedef enum logic [0:0] {StCount, StLoad} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [SW-1:0]    ptr_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SW-1:0]    out_ch_q;
  logic             out_valid_q;

  logic [SW-1:0]    pick;
  logic             avail;
  logic [WIDTH-1:0] sample;
  logic [SW-1:0]    nxt_ptr;
  logic [CW-1:0]    cnt_inc;
  logic             slot_free;
  logic             load;
  int unsigned      idx;

  // Channel choice: manual clamps out-of-range selects to 0; auto takes the first enabled
  // channel at or above the scan pointer, wrapping around.
  always_comb begin
    pick  = '0;
    avail = 1'b0;
    idx   = 0;
    if (!bus.mode) begin
      avail = 1'b1;
      if (32'(bus.sel) < NCH) pick = bus.sel;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        idx = 32'(ptr_q) + i;
        if (idx >= NCH) idx = idx - NCH;
        if (!avail && bus.ch_en[idx]) begin
          avail = 1'b1;
          pick  = SW'(idx);
        end
      end
    end
  end

  always_comb begin
    sample    = bus.ch_data[pick * WIDTH +: WIDTH];
    nxt_ptr   = (pick == LastCh) ? '0 : pick + SW'(1);
    cnt_inc   = cnt_q + CW'(1);
    slot_free = !out_valid_q || bus.out_ready;
    load      = (state_q == StLoad) && slot_free && avail;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLoad;
      cnt_q       <= CntLast;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StCount: begin
          cnt_q <= cnt_inc;
          if (cnt_inc == CntLast) state_q <= StLoad;
        end
        StLoad: begin
          // A stalled load holds the counter at its last value until the slot frees up.
          if (load) begin
            cnt_q   <= '0;
            state_q <= (CntLast == '0) ? StLoad : StCount;
          end
        end
        default: state_q <= StLoad;
      endcase

      if (load) begin
        out_data_q  <= sample;
        out_ch_q    <= pick;
        out_valid_q <= 1'b1;
        if (bus.mode) ptr_q <= nxt_ptr;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_solar_display_sequencer.sv
// Directed bench for solar_display_sequencer: expected samples are queued as each scenario
// is set up and compared as the output handshakes occur.
module tb_solar_display_sequencer;
  localparam int unsigned WIDTH = 12;
  localparam int unsigned NCH   = 5;
  localparam int unsigned DWELL = 4;
  localparam int unsigned SW    = 3;

  typedef struct {
    logic [SW-1:0]    ch;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];
  int unsigned t_rel;
  int unsigned at;
  int unsigned prev;
  bit          got;

  solar_display_sequencer_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  solar_display_sequencer #(.WIDTH(WIDTH), .NCH(NCH), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_chans(input logic [WIDTH-1:0] base);
    for (int k = 0; k < int'(NCH); k++) bus.ch_data[k*WIDTH +: WIDTH] = base + WIDTH'(k);
  endtask

  task automatic push(input int ch, input int data);
    exp_t e;
    e.ch   = SW'(ch);
    e.data = WIDTH'(data);
    sb.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({tag, "_rst_valid"}, 32'(bus.out_valid), 32'h0);
    check({tag, "_rst_data"},  32'(bus.out_data),  32'h0);
    check({tag, "_rst_ch"},    32'(bus.out_ch),    32'h0);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    t_rel = cyc;
  endtask

  task automatic wait_accept(input string tag, output int unsigned when, output bit ok);
    ok   = 1'b0;
    when = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        ok   = 1'b1;
        when = cyc;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s_timeout: observed no handshake, required one within 40 cycles", tag);
    end
  endtask

  task automatic compare_head(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s_sb: observed output with empty queue, required expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_ch"},   32'(bus.out_ch),   32'(e.ch));
      check({tag, "_data"}, 32'(bus.out_data), 32'(e.data));
    end
  endtask

  initial begin
    bus.mode      = 1'b0;
    bus.sel       = 3'd1;
    bus.ch_en     = '0;
    bus.out_ready = 1'b1;
    set_chans(12'h100);

    // Manual sel=1: load on the first edge after reset, then every DWELL cycles.
    bus.ch_data[1*WIDTH +: WIDTH] = 12'h123;
    do_reset("man");
    for (int i = 0; i < 3; i++) push(1, 'h123);
    for (int i = 0; i < 3; i++) begin
      wait_accept("man", at, got);
      if (got) begin
        compare_head("man");
        check("man_gap", at - ((i == 0) ? t_rel : prev), (i == 0) ? 32'd1 : 32'(DWELL));
        prev = at;
      end
    end

    // Auto scan over 10101.
    set_chans(12'h100);
    bus.mode  = 1'b1;
    bus.ch_en = 5'b10101;
    do_reset("auto");
    push(0, 'h100); push(2, 'h102); push(4, 'h104); push(0, 'h100); push(2, 'h102);
    for (int i = 0; i < 5; i++) begin
      wait_accept("auto", at, got);
      if (got) begin
        compare_head("auto");
        check("auto_gap", at - ((i == 0) ? t_rel : prev), (i == 0) ? 32'd1 : 32'(DWELL));
        prev = at;
      end
    end

    // Backpressure: output frozen while stalled, next channel loads on the accept edge.
    bus.out_ready = 1'b0;
    do_reset("stall");
    push(0, 'h100); push(2, 'h102); push(4, 'h104);
    @(negedge clk);
    check("stall_first_valid", 32'(bus.out_valid), 32'h1);
    compare_head("stall_first");
    repeat (10) @(negedge clk);
    check("stall_hold_valid", 32'(bus.out_valid), 32'h1);
    check("stall_hold_ch",    32'(bus.out_ch),    32'h0);
    check("stall_hold_data",  32'(bus.out_data),  32'h100);
    bus.out_ready = 1'b1;
    @(negedge clk);
    prev = cyc;
    check("stall_b2b_valid", 32'(bus.out_valid), 32'h1);
    compare_head("stall_b2b");
    @(negedge clk);
    check("stall_drain_valid", 32'(bus.out_valid), 32'h0);
    wait_accept("stall_next", at, got);
    if (got) begin
      compare_head("stall_next");
      check("stall_next_gap", at - prev, 32'(DWELL));
    end

    // Manual select out of range falls back to channel 0.
    bus.mode = 1'b0;
    bus.sel  = 3'd6;
    bus.ch_data[0*WIDTH +: WIDTH] = 12'hABC;
    do_reset("oor");
    push(0, 'hABC);
    wait_accept("oor", at, got);
    if (got) compare_head("oor");

    // Auto with nothing enabled: output drains and stays idle until a channel is enabled.
    set_chans(12'h100);
    bus.mode  = 1'b1;
    bus.ch_en = 5'b10101;
    do_reset("none");
    @(negedge clk);
    push(0, 'h100);
    compare_head("none_first");
    bus.ch_en = '0;
    @(negedge clk);
    check("none_clear_valid", 32'(bus.out_valid), 32'h0);
    repeat (8) @(negedge clk);
    check("none_idle_valid", 32'(bus.out_valid), 32'h0);
    bus.ch_en = 5'b01000;
    push(3, 'h103);
    @(negedge clk);
    check("none_en_valid", 32'(bus.out_valid), 32'h1);
    compare_head("none_en");

    // Reset in the middle of a stall discards the held sample.
    bus.ch_en     = 5'b10101;
    bus.out_ready = 1'b0;
    do_reset("rstmid");
    @(negedge clk);
    check("rstmid_pre_valid", 32'(bus.out_valid), 32'h1);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_valid", 32'(bus.out_valid), 32'h0);
    check("rstmid_data",  32'(bus.out_data),  32'h0);
    check("rstmid_ch",    32'(bus.out_ch),    32'h0);
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    push(0, 'h100);
    @(negedge clk);
    check("rstmid_after_valid", 32'(bus.out_valid), 32'h1);
    compare_head("rstmid_after");

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/solar_display_sequencer.md
SOLAR_DISPLAY_SEQUENCER -- requirements
Module: solar_display_sequencer

Interface
REQ-001 Parameter WIDTH, default 12: bit width of each display channel value.
REQ-002 Parameter NCH, default 5: number of display channels (2..16); SW = max(1, clog2(NCH)).
REQ-003 Parameter DWELL, default 1024: clock cycles between successive samples (>= 1).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ch_data  input  NCH*WIDTH  packed channel values; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 mode  input  1  0 = manual (sel chooses channel), 1 = auto-scan over enabled channels.
REQ-008 sel  input  SW  manual-mode channel select.
REQ-009 ch_en  input  NCH  auto-scan channel enable mask; bit k enables channel k.
REQ-010 out_data  output  WIDTH  registered sampled value.
REQ-011 out_ch  output  SW  index of the channel held in out_data.
REQ-012 out_valid  output  1  out_data/out_ch hold an unconsumed sample.
REQ-013 out_ready  input  1  consumer accepts the sample when out_valid && out_ready at a rising edge.

Function
REQ-014 Two states: COUNT (dwell counter cnt advancing) and LOAD (cnt == DWELL-1; sample event pending).
REQ-015 In COUNT, cnt increments by 1 each cycle; on reaching DWELL-1 the block is in LOAD.
REQ-016 Output slot is free in a cycle when !out_valid || out_ready.
REQ-017 In LOAD with slot free and a channel available: capture out_data, out_ch, set out_valid=1, cnt<=0 (to COUNT); DWELL=1 yields a load every free cycle.
REQ-018 In LOAD with slot busy: stall; cnt, scan pointer and outputs hold; no sample is dropped or overwritten.
REQ-019 out_valid && out_ready with no load in the same cycle: out_valid<=0; out_data, out_ch hold their last values.
REQ-020 Accept and load in the same cycle: new sample replaces old, out_valid stays 1 (back-to-back, zero bubble).
REQ-021 Manual mode: sampled channel = sel; sel >= NCH samples channel 0 and reports out_ch=0; ch_en ignored.
REQ-022 Auto mode: sampled channel = first enabled index searching upward from scan pointer ptr, wrapping NCH-1 -> 0; after load ptr <= sampled index + 1, wrapping NCH -> 0.
REQ-023 Auto mode, single enabled channel: that channel sampled repeatedly.
REQ-024 Auto mode, ch_en == 0: no channel available; remain in LOAD, no load, out_valid clears normally per REQ-019.
REQ-025 mode, sel, ch_en changes take effect at the next load only; ptr is kept across mode switches.
REQ-026 ch_data sampled on the load edge itself; latency from load-cycle input to out_data = 1 clock.

Reset
REQ-027 rst asserted: out_data=0, out_ch=0, out_valid=0, ptr=0, cnt=DWELL-1 (state LOAD), immediately and asynchronously.
REQ-028 First load occurs at the first rising edge after rst deasserts (given a channel is available).
REQ-029 rst asserted mid-stall or mid-dwell discards the pending sample; no partial state survives.

Verification
REQ-030 WIDTH=12, NCH=5, DWELL=4, manual, sel=1, ch1=0x123, out_ready=1 -> out_valid=1, out_data=0x123, out_ch=1 on first edge after reset, reload every 4 cycles.
REQ-031 Auto, ch_en=5'b10101, channel k = 0x100+k, out_ready=1 -> out_ch sequence 0,2,4,0,2, one load per 4 cycles.
REQ-032 Auto, out_ready=0 for 10 cycles after first load -> out_data/out_ch frozen, cnt stalled at 3; ready=1 -> next channel loaded same edge, no skipped channel.
REQ-033 Manual, sel=6 (>= NCH), ch0=0xABC -> out_data=0xABC, out_ch=0.
REQ-034 Auto, ch_en=0 -> after one accept out_valid=0 and stays 0; set ch_en=5'b01000 -> next edge loads channel 3.
REQ-035 Assert rst during a stall with out_valid=1 -> all outputs 0 immediately; after release first load on next edge.
